// File: rtl/fxp_arith_unit.sv
// fxp_arith_unit: clocked sign-magnitude fixed-point arithmetic engine.
// add/sub/mul/abs complete in one cycle; divide is a restoring divider
// producing one quotient bit per cycle. Rounding of mul/div is enabled
// by defining FXP_ROUND_EN (otherwise results truncate toward zero).
module fxp_arith_unit #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             ovf,
  output logic             div_by_zero
);

  localparam int MW = WIDTH - 1;        // magnitude width
  localparam int PW = 2 * MW;           // full magnitude product width
`ifdef FXP_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int QW = MW + FRAC + RND;  // dividend / quotient bits
  localparam int CW = $clog2(QW + 1);

  typedef enum logic {ST_IDLE, ST_DIV} state_e;

  typedef struct packed {
    logic          ovf;
    logic          sign;
    logic [MW-1:0] mag;
  } sm_res_t;

  // Sign-magnitude add with saturation on magnitude carry.
  function automatic sm_res_t add_sm(input logic sa, input logic [MW-1:0] ma,
                                     input logic sb, input logic [MW-1:0] mb);
    sm_res_t      r;
    logic [MW:0]  sum;
    r   = '0;
    sum = {1'b0, ma} + {1'b0, mb};
    if (sa == sb) begin
      r.sign = sa;
      if (sum[MW]) begin
        r.mag = '1;
        r.ovf = 1'b1;
      end else begin
        r.mag = sum[MW-1:0];
      end
    end else if (ma >= mb) begin
      r.sign = sa;
      r.mag  = ma - mb;
    end else begin
      r.sign = sb;
      r.mag  = mb - ma;
    end
    return r;
  endfunction

  // Any zero magnitude leaves the unit as +0.
  function automatic logic [WIDTH-1:0] pack(input logic s, input logic [MW-1:0] m);
    return (m == '0) ? '0 : {s, m};
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [MW-1:0]    rem_q, rem_d;
  logic [QW-1:0]    quo_q, quo_d;
  logic [MW-1:0]    dvs_q, dvs_d;
  logic             sgn_q, sgn_d;
  logic             sa_q, sa_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic             sgn_a, sgn_b;
  logic [MW-1:0]    mag_a, mag_b;
  logic             accept;
  sm_res_t          add_r;
  logic [PW-1:0]    prod, prod_sh;
  logic             mul_ovf;
  logic [MW:0]      rem_sh;
  logic             q_bit;
  logic [QW-1:0]    q_fin;

  assign sgn_a    = a[WIDTH-1];
  assign sgn_b    = b[WIDTH-1];
  assign mag_a    = a[MW-1:0];
  assign mag_b    = b[MW-1:0];
  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready;

  // Next-state logic: op decode, one divider iteration, divide finalisation.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    sgn_d       = sgn_q;
    sa_d        = sa_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;

    // Add/sub share one adder; sub flips b's sign.
    add_r = add_sm(sgn_a, mag_a, sgn_b ^ op[0], mag_b);

    // Multiply: magnitude product scaled back by FRAC.
    prod = PW'(mag_a) * PW'(mag_b);
`ifdef FXP_ROUND_EN
    prod = prod + (PW'(1) << (FRAC - 1));
`endif
    prod_sh = prod >> FRAC;
    mul_ovf = |prod_sh[PW-1:MW];

    // One restoring-divide step: shift in next dividend bit, trial subtract.
    rem_sh = {rem_q, quo_q[QW-1]};
    q_bit  = (rem_sh >= {1'b0, dvs_q});

    // Final quotient; the extra bit is folded in as round-half-up.
`ifdef FXP_ROUND_EN
    q_fin = (quo_q >> 1) + QW'(quo_q[0]);
`else
    q_fin = quo_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            3'b000, 3'b001: begin
              result_d    = pack(add_r.sign, add_r.mag);
              ovf_d       = add_r.ovf;
              dbz_d       = 1'b0;
              out_valid_d = 1'b1;
            end
            3'b010: begin
              result_d    = pack(sgn_a ^ sgn_b, mul_ovf ? '1 : prod_sh[MW-1:0]);
              ovf_d       = mul_ovf;
              dbz_d       = 1'b0;
              out_valid_d = 1'b1;
            end
            3'b011: begin
              state_d = ST_DIV;
              cnt_d   = '0;
              rem_d   = '0;
              quo_d   = QW'(mag_a) << (FRAC + RND);
              dvs_d   = mag_b;
              sgn_d   = sgn_a ^ sgn_b;
              sa_d    = sgn_a && (mag_a != '0);
            end
            default: begin
              result_d    = {1'b0, mag_a};
              ovf_d       = 1'b0;
              dbz_d       = 1'b0;
              out_valid_d = 1'b1;
            end
          endcase
        end
      end
      ST_DIV: begin
        if (cnt_q != CW'(QW)) begin
          cnt_d = cnt_q + CW'(1);
          rem_d = q_bit ? (rem_sh[MW-1:0] - dvs_q) : rem_sh[MW-1:0];
          quo_d = {quo_q[QW-2:0], q_bit};
        end else begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          if (dvs_q == '0) begin
            result_d = {sa_q, {MW{1'b1}}};
            ovf_d    = 1'b1;
            dbz_d    = 1'b1;
          end else if (|q_fin[QW-1:MW]) begin
            result_d = {sgn_q, {MW{1'b1}}};
            ovf_d    = 1'b1;
            dbz_d    = 1'b0;
          end else begin
            result_d = pack(sgn_q, q_fin[MW-1:0]);
            ovf_d    = 1'b0;
            dbz_d    = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers; reset wins over any acceptance.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
    end
  end

  // Divider datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are not reset; they are always reloaded when a divide is accepted.
    cnt_q <= cnt_d;
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
    sgn_q <= sgn_d;
    sa_q  <= sa_d;
  end

  assign result      = result_q;
  assign out_valid   = out_valid_q;
  assign ovf         = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_fxp_arith_unit.sv
// Directed testbench for fxp_arith_unit (Q15.16, default build).
module tb_fxp_arith_unit;

  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
`ifdef FXP_ROUND_EN
  localparam int DIV_LAT = WIDTH + FRAC + 1;
`else
  localparam int DIV_LAT = WIDTH + FRAC;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_ABS = 3'b100;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH-1:0] result;
  logic             out_valid, ovf, div_by_zero;

  int checks = 0;
  int errors = 0;

  fxp_arith_unit #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .result      (result),
    .out_valid   (out_valid),
    .ovf         (ovf),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present one operation for a single edge, then sample #1 after that edge.
  task automatic issue(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid rises, bounded by limit.
  task automatic wait_out(input int limit, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;

    rst      = 1'b1;
    in_valid = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_dbz", div_by_zero, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // add 1.5 + 1.0 followed back-to-back by sub 1.0 - 1.5
    op = OP_ADD; a = 32'h0001_8000; b = 32'h0001_0000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("add_valid", out_valid, 1'b1);
    check("add_result", result, 32'h0002_8000);
    check("add_ovf", ovf, 1'b0);
    check("add_ready", in_ready, 1'b1);
    op = OP_SUB; a = 32'h0001_0000; b = 32'h0001_8000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("sub_valid", out_valid, 1'b1);
    check("sub_result", result, 32'h8000_8000);
    @(posedge clk);
    #1;
    check("pulse_low", out_valid, 1'b0);
    check("hold_result", result, 32'h8000_8000);

    // opposite signs, equal magnitude -> +0
    issue(OP_ADD, 32'h0001_0000, 32'h8001_0000);
    check("add_cancel", result, 32'h0);

    // multiply
    issue(OP_MUL, 32'h0001_8000, 32'h8002_0000);
    check("mul_neg", result, 32'h8003_0000);
    check("mul_neg_ovf", ovf, 1'b0);
    issue(OP_MUL, 32'h0000_F000, 32'h0001_0000);
    check("mul_frac", result, 32'h0000_F000);
    issue(OP_MUL, 32'h0001_0000, 32'h8000_0000);
    check("mul_negzero", result, 32'h0);
    issue(OP_MUL, 32'h0100_0000, 32'h0100_0000);
    check("mul_sat", result, 32'h7FFF_FFFF);
    check("mul_sat_ovf", ovf, 1'b1);

    // divide 3.0 / 2.0 with an ignored in_valid pulse while busy
    issue(OP_DIV, 32'h0003_0000, 32'h0002_0000);
    check("div_busy", in_ready, 1'b0);
    check("div_no_early", out_valid, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      if (n == 5) begin
        op = OP_ADD; a = 32'h0001_0000; b = 32'h0001_0000; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check("div_latency", n, DIV_LAT);
    check("div_result", result, 32'h0001_8000);
    check("div_ready_back", in_ready, 1'b1);
    check("div_ovf", ovf, 1'b0);
    check("div_dbz", div_by_zero, 1'b0);
    @(posedge clk);
    #1;
    check("div_pulse_low", out_valid, 1'b0);

    // divide by zero
    issue(OP_DIV, 32'h8001_0000, 32'h0);
    wait_out(200, n);
    check("dbz_latency", n, DIV_LAT);
    check("dbz_result", result, 32'hFFFF_FFFF);
    check("dbz_flag", div_by_zero, 1'b1);
    check("dbz_ovf", ovf, 1'b1);

    // divide quotient overflow
    issue(OP_DIV, 32'h7FFF_0000, 32'h8000_0001);
    wait_out(200, n);
    check("divsat_result", result, 32'hFFFF_FFFF);
    check("divsat_ovf", ovf, 1'b1);
    check("divsat_dbz", div_by_zero, 1'b0);

    // add saturation and abs
    issue(OP_ADD, 32'h7FFF_0000, 32'h7FFF_0000);
    check("addsat_result", result, 32'h7FFF_FFFF);
    check("addsat_ovf", ovf, 1'b1);
    issue(OP_ABS, 32'h8000_8000, 32'h1234_5678);
    check("abs_result", result, 32'h0000_8000);
    check("abs_ovf", ovf, 1'b0);

    // reset mid-divide
    issue(OP_DIV, 32'h0003_0000, 32'h0002_0000);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_ready", in_ready, 1'b1);
    check("mid_rst_result", result, 32'h0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ovf", ovf, 1'b0);
    pulses = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) pulses++;
    end
    check("mid_rst_no_pulse", pulses, 0);
    issue(OP_ADD, 32'h0001_0000, 32'h0001_0000);
    check("post_rst_valid", out_valid, 1'b1);
    check("post_rst_add", result, 32'h0002_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
